// File: rtl/pipeline_trace_buffer_if.sv
// Trace output stream of pipeline_trace_buffer: one record per beat, valid/ready handshake.
// A beat transfers on a rising clock edge where trace_valid and trace_ready are both high; the
// producer keeps the payload stable while trace_valid is high and trace_ready is low.
interface pipeline_trace_buffer_if #(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 6,
  parameter int CNT_W  = 16
) ();
  logic              trace_valid;
  logic              trace_ready;
  logic              trace_kind;
  logic [CNT_W-1:0]  trace_stamp;
  logic [XLEN-1:0]   trace_pc;
  logic [MEM_AW-1:0] trace_addr;
  logic [XLEN-1:0]   trace_data;

  modport master (
    output trace_valid,
    input  trace_ready,
    output trace_kind,
    output trace_stamp,
    output trace_pc,
    output trace_addr,
    output trace_data
  );

  modport slave (
    input  trace_valid,
    output trace_ready,
    input  trace_kind,
    input  trace_stamp,
    input  trace_pc,
    input  trace_addr,
    input  trace_data
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Snoops register writebacks and stores, stamps them with a cycle count and queues them in a
// first-word-fall-through circular FIFO that drains over the trace stream interface.
module pipeline_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 6,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               cfg_en,
  input  logic                     flush,
  input  logic [XLEN-1:0]          pc,
  input  logic                     wb_en,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     st_en,
  input  logic [MEM_AW-1:0]        st_addr,
  input  logic [XLEN-1:0]          st_data,
  pipeline_trace_buffer_if.master  trace,
  output logic                     stall_req,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef struct packed {
    logic              kind;
    logic [CNT_W-1:0]  stamp;
    logic [XLEN-1:0]   pc;
    logic [MEM_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             q_st, q_wb;
  logic             push_st, push_wb;
  logic             pop;
  logic [1:0]       n_req, n_push, n_drop;
  logic [LVL_W-1:0] free;
  logic [PTR_W-1:0] wb_slot;
  logic [CNT_W:0]   drop_sum;
  rec_t             st_rec, wb_rec, head_rec;

  assign q_st  = st_en & cfg_en[1];
  assign q_wb  = wb_en & cfg_en[0] & (wb_addr != '0);
  assign n_req = {1'b0, q_st} + {1'b0, q_wb};

  // Room is judged on the pre-pop level; the store wins a single remaining slot.
  assign free = DEPTH_L - level_q;

  always_comb begin
    push_st = 1'b0;
    push_wb = 1'b0;
    if (free >= LVL_W'(2)) begin
      push_st = q_st;
      push_wb = q_wb;
    end else if (free == LVL_W'(1)) begin
      push_st = q_st;
      push_wb = q_wb & ~q_st;
    end
  end

  assign n_push  = {1'b0, push_st} + {1'b0, push_wb};
  assign n_drop  = n_req - n_push;
  assign pop     = (level_q != '0) & trace.trace_ready;
  assign wb_slot = push_st ? tail_q + PTR_W'(1) : tail_q;

  always_comb begin
    st_rec       = '0;
    st_rec.kind  = 1'b1;
    st_rec.stamp = cycle_q;
    st_rec.pc    = pc;
    st_rec.addr  = st_addr;
    st_rec.data  = st_data;
    wb_rec       = '0;
    wb_rec.kind  = 1'b0;
    wb_rec.stamp = cycle_q;
    wb_rec.pc    = pc;
    wb_rec.addr  = MEM_AW'(wb_addr);
    wb_rec.data  = wb_data;
  end

  assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(n_drop);

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(n_push);
    level_d = level_q + LVL_W'(n_push) - LVL_W'(pop);
    drop_d  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
      drop_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      cycle_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      drop_q  <= drop_d;
      cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  // Storage is cleared on reset so the idle trace fields read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush) begin
      if (push_st) mem_q[tail_q] <= st_rec;
      if (push_wb) mem_q[wb_slot] <= wb_rec;
    end
  end

  assign head_rec          = mem_q[head_q];
  assign trace.trace_valid = (level_q != '0);
  assign trace.trace_kind  = head_rec.kind;
  assign trace.trace_stamp = head_rec.stamp;
  assign trace.trace_pc    = head_rec.pc;
  assign trace.trace_addr  = head_rec.addr;
  assign trace.trace_data  = head_rec.data;

  assign stall_req  = (level_q >= DEPTH_L - LVL_W'(1));
  assign drop_count = drop_q;
  assign level      = level_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the trace log.
module tb_pipeline_trace_buffer;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int MEM_AW = 6;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int REC_W  = 1 + CNT_W + XLEN + MEM_AW + XLEN;

  logic              clk;
  logic              rst;
  logic [1:0]        cfg_en;
  logic              flush;
  logic [XLEN-1:0]   pc;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              st_en;
  logic [MEM_AW-1:0] st_addr;
  logic [XLEN-1:0]   st_data;
  logic              stall_req;
  logic [CNT_W-1:0]  drop_count;
  logic [$clog2(DEPTH):0] level;

  pipeline_trace_buffer_if #(.XLEN(XLEN), .MEM_AW(MEM_AW), .CNT_W(CNT_W)) trace_if ();

  pipeline_trace_buffer #(
    .XLEN(XLEN), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .flush(flush), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .trace(trace_if), .stall_req(stall_req), .drop_count(drop_count), .level(level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected log in order, {kind, stamp, pc, addr, data}
  logic [REC_W-1:0] exp_q[$];
  logic [CNT_W-1:0] cyc_m;
  logic [CNT_W-1:0] drop_m;
  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic kind, input logic [CNT_W-1:0] stamp,
      input logic [XLEN-1:0] p, input logic [MEM_AW-1:0] a, input logic [XLEN-1:0] d);
    return {kind, stamp, p, a, d};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cyc_m  = '0;
    drop_m = '0;
  endtask

  task automatic model_drop();
    if (drop_m != {CNT_W{1'b1}}) drop_m = drop_m + 1'b1;
  endtask

  // Applies the rules of one clock edge to the expected log.
  task automatic model_edge();
    int room;
    if (!rst) begin
      model_reset();
      return;
    end
    room = DEPTH - exp_q.size();
    if (flush) begin
      exp_q.delete();
      drop_m = '0;
    end else begin
      if (exp_q.size() > 0 && trace_if.trace_ready) void'(exp_q.pop_front());
      if (st_en && cfg_en[1]) begin
        if (room > 0) begin
          exp_q.push_back(mk_rec(1'b1, cyc_m, pc, st_addr, st_data));
          room--;
        end else model_drop();
      end
      if (wb_en && cfg_en[0] && wb_addr != 0) begin
        if (room > 0) exp_q.push_back(mk_rec(1'b0, cyc_m, pc, {1'b0, wb_addr}, wb_data));
        else model_drop();
      end
    end
    cyc_m = cyc_m + 1'b1;
  endtask

  task automatic check_outputs();
    logic [REC_W-1:0] h;
    check("level", level, exp_q.size());
    check("trace_valid", trace_if.trace_valid, exp_q.size() > 0);
    check("stall_req", stall_req, (DEPTH - exp_q.size()) < 2);
    check("drop_count", drop_count, drop_m);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("trace_kind", trace_if.trace_kind, h[REC_W-1]);
      check("trace_stamp", trace_if.trace_stamp, h[REC_W-2 -: CNT_W]);
      check("trace_pc", trace_if.trace_pc, h[XLEN+MEM_AW+XLEN-1 -: XLEN]);
      check("trace_addr", trace_if.trace_addr, h[XLEN+MEM_AW-1 -: MEM_AW]);
      check("trace_data", trace_if.trace_data, h[XLEN-1:0]);
    end
  endtask

  // driver tasks: inputs change at the falling edge, outputs are sampled there too
  task automatic step();
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    flush   = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    st_en   = 1'b0;
    st_addr = '0;
    st_data = '0;
  endtask

  task automatic drive_st(input logic [MEM_AW-1:0] a, input logic [XLEN-1:0] d,
      input logic [XLEN-1:0] p);
    st_en = 1'b1; st_addr = a; st_data = d; pc = p;
  endtask

  task automatic drive_wb(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d,
      input logic [XLEN-1:0] p);
    wb_en = 1'b1; wb_addr = a; wb_data = d; pc = p;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", trace_if.trace_valid, 0);
    check("rst_stall", stall_req, 0);
    check("rst_drop", drop_count, 0);
    check("rst_fields", {trace_if.trace_kind, trace_if.trace_stamp, trace_if.trace_pc,
                         trace_if.trace_addr, trace_if.trace_data}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [CNT_W-1:0] st_stamp;
    n_chk  = 0;
    n_fail = 0;
    cfg_en = 2'b11;
    pc     = '0;
    trace_if.trace_ready = 1'b0;
    idle();
    model_reset();
    do_reset();

    // first event after release is stamped 0
    trace_if.trace_ready = 1'b1;
    drive_wb(5'd1, 32'h55, 32'h4);
    step();
    idle();
    check("first_stamp", trace_if.trace_stamp, 0);
    for (int i = 1; i < 5; i++) step();

    // single writeback in cycle 5
    drive_wb(5'd3, 32'h0000_002A, 32'h10);
    step();
    idle();
    check("wb_valid", trace_if.trace_valid, 1);
    check("wb_kind", trace_if.trace_kind, 0);
    check("wb_addr", trace_if.trace_addr, 3);
    check("wb_data", trace_if.trace_data, 32'h2A);
    check("wb_pc", trace_if.trace_pc, 32'h10);
    check("wb_stamp", trace_if.trace_stamp, 5);
    step();
    check("wb_drained", trace_if.trace_valid, 0);

    // dual event: store first, then writeback with the same stamp; x0 filtered
    drive_st(6'h08, 32'hDEAD_BEEF, 32'h20);
    drive_wb(5'd7, 32'h1234_5678, 32'h20);
    step();
    idle();
    check("dual_first_kind", trace_if.trace_kind, 1);
    st_stamp = trace_if.trace_stamp;
    step();
    check("dual_second_kind", trace_if.trace_kind, 0);
    check("dual_same_stamp", trace_if.trace_stamp, st_stamp);
    step();
    drive_wb(5'd0, 32'hFFFF_FFFF, 32'h24);
    step();
    idle();
    check("x0_filtered", level, 0);
    step();

    // overflow with the consumer stalled
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(0, 1)) drive_st(MEM_AW'($urandom), $urandom, $urandom);
      else drive_wb(REG_AW'($urandom_range(1, 31)), $urandom, $urandom);
      step();
      idle();
    end
    check("ovf_level15", level, 15);
    check("ovf_stall", stall_req, 1);
    drive_st(6'h3C, 32'hA5A5_0001, 32'h40);
    drive_wb(5'd9, 32'hA5A5_0002, 32'h40);
    step();
    idle();
    check("ovf_level16", level, 16);
    check("ovf_drop1", drop_count, 1);
    drive_st(6'h3D, 32'hA5A5_0003, 32'h44);
    step();
    idle();
    check("ovf_drop2", drop_count, 2);

    // reset in the middle of a drain loses everything
    trace_if.trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    drive_wb(5'd2, 32'h77, 32'h80);
    step();
    idle();
    check("post_rst_stamp", trace_if.trace_stamp, 0);
    step();

    // wrap-around streaming
    for (int i = 0; i < 40; i++) begin
      drive_st(MEM_AW'(i), XLEN'(i), XLEN'(32'h100 + 4 * i));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    check("wrap_drop", drop_count, 0);
    check("wrap_empty", level, 0);

    // flush with level 6 and drop_count 3
    trace_if.trace_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive_st(MEM_AW'($urandom), $urandom, $urandom);
      step();
    end
    idle();
    trace_if.trace_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("pre_flush_level", level, 6);
    check("pre_flush_drop", drop_count, 3);
    trace_if.trace_ready = 1'b0;
    flush = 1'b1;
    drive_st(6'h11, 32'hCAFE_F00D, 32'h200);
    step();
    idle();
    check("flush_level", level, 0);
    check("flush_valid", trace_if.trace_valid, 0);
    check("flush_drop", drop_count, 0);
    drive_wb(5'd4, 32'h99, 32'h204);
    step();
    idle();
    check("flush_stamp_continues", trace_if.trace_stamp, cyc_m - 1'b1);
    trace_if.trace_ready = 1'b1;
    step();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cfg_en  = 2'($urandom);
      flush   = ($urandom_range(0, 63) == 0);
      pc      = $urandom;
      wb_en   = $urandom_range(0, 1);
      wb_addr = REG_AW'($urandom_range(0, 7));
      wb_data = $urandom;
      st_en   = $urandom_range(0, 1);
      st_addr = MEM_AW'($urandom);
      st_data = $urandom;
      trace_if.trace_ready = ($urandom_range(0, 3) != 0) ^ (i % 128 >= 96);
      step();
    end
    idle();
    trace_if.trace_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
